instr_fetch: RTL
================

# instr_fetch

Instruction fetch and sequencing unit for the 8-bit accumulator-style core: drives the instruction ROM address, presents the returned instruction byte to the datapath, and computes the next PC. It resolves `branch`/`branchb` and `halt` itself, taking the branch condition flag and the offset register value from the datapath. It also counts executed instructions. It sits between the instruction ROM (combinational, 8-bit address in, 8-bit data out) and the decode/execute datapath.

## Interface
- No parameters. Widths are fixed: PC 8 bits, instruction 8 bits, counter 16 bits.
- `clk_i` in 1: single clock; all state updates on rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle pulse that launches a program at `start_addr_i`.
- `start_addr_i` in 8: program entry address (programs currently at 0, 100, 152).
- `rom_data_i` in 8: instruction byte returned by the ROM for `rom_addr_o`, same cycle.
- `cond_i` in 1: registered condition flag from the datapath (set by `seq`/`slt`).
- `offset_i` in 8: value of register `instr[2:0]`, read combinationally by the datapath.
- `rom_addr_o` out 8: current PC.
- `instr_o` out 8: instruction to execute; 0 when not running.
- `instr_valid_o` out 1: high only in RUN; the datapath commits state only when high.
- `rs_o` out 3: `rom_data_i[2:0]`, the register-file read select for `offset_i`.
- `done_o` out 1: high in HALTED.
- `icount_o` out 16: instructions executed since the last start, saturating.

## Operation
- States: IDLE (after reset), RUN, HALTED.
- IDLE/HALTED + `start_i` -> RUN. On the same edge: PC <= `start_addr_i`, `icount_o` <= 0.
- `start_i` in RUN is ignored.
- In RUN, each cycle executes exactly one instruction, `I = rom_data_i` at PC.
- Decode, in priority order:
  - `I == 8'b10001000` (halt): PC holds, go to HALTED.
  - `I[7:3] == 5'b11110` (branch): if `cond_i`, PC <= PC + `offset_i`; else PC <= PC + 1.
  - `I[7:3] == 5'b10110` (branchb): if `cond_i`, PC <= PC - `offset_i`; else PC <= PC + 1.
  - Anything else: PC <= PC + 1.
- All PC arithmetic is modulo 256 (wraps silently); offset is unsigned 8-bit.
- `icount_o` increments once per RUN cycle, including the halt cycle, and saturates at 16'hFFFF.
- In IDLE/HALTED, `instr_o` = 0 and `instr_valid_o` = 0. `rom_addr_o` keeps showing PC, so the halt address is visible after completion.
- `rs_o` is always `rom_data_i[2:0]`, independent of state.

## Timing
- Reset values: state IDLE, PC 0 (`rom_addr_o` = 0), `instr_o` 0, `instr_valid_o` 0, `done_o` 0, `icount_o` 0.
- Reset mid-RUN aborts immediately (asynchronous); there is no partial-commit guarantee beyond `instr_valid_o` dropping.
- Zero-latency fetch: the ROM is combinational, so `instr_o` equals `rom_data_i` in the same cycle PC is presented.
- Taken and untaken branches both cost 1 cycle; there are no bubbles.
- `start_i` edge -> first `instr_valid_o` high on the next cycle.
- Halt at cycle N -> `done_o` high from cycle N+1.
- `cond_i` and `offset_i` are sampled on the edge that ends the branch cycle and must be stable before it.

## Structure
- Shared package `core_pkg`:
  - `OP_HALT` = 8'b10001000
  - `OP_BR_HI` = 5'b11110
  - `OP_BRB_HI` = 5'b10110
  - state enum `fetch_state_t` {IDLE, RUN, HALTED}
  - `PC_W` = 8
- One sub-module, `pc_next`: purely combinational. Inputs: PC, instruction, `cond_i`, `offset_i`. Outputs: next PC and an `is_halt` flag.
- The state register, PC register and counter stay in `instr_fetch`.

## Test plan
- Straight-line program: ROM holds non-branch bytes at 100..112 and `halt` at 113; pulse start with addr 100. Expect `done_o` high after 14 RUN cycles, `icount_o` = 14, `rom_addr_o` = 113.
- Forward branch: PC 16, `I` = 8'b11110111, `offset_i` = 8. With `cond_i` = 1, next PC = 24; with `cond_i` = 0, next PC = 17.
- Backward branch: PC 49, `I` = 8'b10110110, `offset_i` = 38, `cond_i` = 1. Expect next PC = 11.
- Wrap-around: PC 250, branch taken with offset 10 -> 4. PC 3, branchb taken with offset 5 -> 254. PC 255, non-branch -> 0.
- Control edges:
  - `start_i` pulsed mid-RUN: PC and `icount_o` are unaffected.
  - `start_i` in HALTED with addr 152: restarts, `icount_o` clears to 0.
  - `rst_i` asserted mid-RUN: all outputs return to reset values immediately, without waiting for a clock edge.
- Saturation: force `icount_o` to 16'hFFFE, run 3 more instructions. Expect it to hold at 16'hFFFF.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the 8-bit accumulator core's fetch unit.
//   PC_W, CNT_W    : program counter and instruction counter widths
//   OP_HALT        : full opcode byte of the halt instruction
//   OP_BR_HI       : upper five bits of a forward branch (branch)
//   OP_BRB_HI      : upper five bits of a backward branch (branchb)
//   fetch_state_t  : sequencing state of the fetch unit
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  localparam logic [7:0] OP_HALT   = 8'b10001000;
  localparam logic [4:0] OP_BR_HI  = 5'b11110;
  localparam logic [4:0] OP_BRB_HI = 5'b10110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles the fetch unit's ROM, datapath and control signals.
//   start_i, start_addr_i : program launch pulse and entry address
//   rom_data_i            : instruction byte returned for rom_addr_o
//   cond_i, offset_i      : branch condition flag and offset register value
//   rom_addr_o            : current PC
//   instr_o, instr_valid_o: instruction to execute and its commit enable
//   rs_o                  : register select used to produce offset_i
//   done_o, icount_o      : completion flag and executed-instruction count
// master = fetch unit, slave = ROM / datapath / controller side.
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  import core_pkg::*;

  logic                start_i;
  logic [PC_W-1:0]     start_addr_i;
  logic [7:0]          rom_data_i;
  logic                cond_i;
  logic [7:0]          offset_i;
  logic [PC_W-1:0]     rom_addr_o;
  logic [7:0]          instr_o;
  logic                instr_valid_o;
  logic [2:0]          rs_o;
  logic                done_o;
  logic [CNT_W-1:0]    icount_o;

  modport master (
    input  start_i, start_addr_i, rom_data_i, cond_i, offset_i,
    output rom_addr_o, instr_o, instr_valid_o, rs_o, done_o, icount_o
  );

  modport slave (
    output start_i, start_addr_i, rom_data_i, cond_i, offset_i,
    input  rom_addr_o, instr_o, instr_valid_o, rs_o, done_o, icount_o
  );

endinterface

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Purely combinational next-PC logic for the fetch unit.
//   pc      in  : current program counter
//   instr   in  : instruction byte at pc
//   cond    in  : branch condition flag from the datapath
//   offset  in  : unsigned branch distance from the register file
//   next_pc out : PC for the following cycle (modulo 256)
//   is_halt out : instr is the halt opcode
// ---------------------------------------------------------------------------
module pc_next
  import core_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      instr,
  input  logic            cond,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] next_pc,
  output logic            is_halt
);

  // Halt is checked first; its encoding never overlaps either branch prefix,
  // but keeping the priority explicit makes the intent obvious.
  always_comb begin
    next_pc = pc + 8'd1;
    is_halt = 1'b0;
    if (instr == OP_HALT) begin
      next_pc = pc;
      is_halt = 1'b1;
    end else if (instr[7:3] == OP_BR_HI) begin
      if (cond) next_pc = pc + offset;
    end else if (instr[7:3] == OP_BRB_HI) begin
      if (cond) next_pc = pc - offset;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch and sequencing unit. Presents the PC to a combinational
// ROM, forwards the returned byte to the datapath while running, resolves
// branch/branchb/halt locally and counts executed instructions.
//   clk_i : clock, all state updates on the rising edge
//   rst_i : asynchronous active-high reset
//   bus   : instr_fetch_if.master (start, ROM, branch inputs, status outputs)
// ---------------------------------------------------------------------------
module instr_fetch
  import core_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  instr_fetch_if.master bus
);

  fetch_state_t     state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] icount;
  logic [PC_W-1:0]  next_pc;
  logic             is_halt;

  pc_next u_pc_next (
    .pc      (pc),
    .instr   (bus.rom_data_i),
    .cond    (bus.cond_i),
    .offset  (bus.offset_i),
    .next_pc (next_pc),
    .is_halt (is_halt)
  );

  // Sequencer: start is only honoured outside RUN; every RUN cycle retires
  // one instruction, including the halt itself, so the count covers it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      pc     <= '0;
      icount <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (bus.start_i) begin
            state  <= RUN;
            pc     <= bus.start_addr_i;
            icount <= '0;
          end
        end
        RUN: begin
          pc <= next_pc;
          if (icount != '1) icount <= icount + 16'd1;
          if (is_halt) state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The ROM is combinational, so the instruction is forwarded in the same
  // cycle its address is shown; outside RUN the datapath sees a zero byte.
  assign bus.rom_addr_o    = pc;
  assign bus.instr_valid_o = (state == RUN);
  assign bus.instr_o       = (state == RUN) ? bus.rom_data_i : 8'd0;
  assign bus.done_o        = (state == HALTED);
  assign bus.rs_o          = bus.rom_data_i[2:0];
  assign bus.icount_o      = icount;

endmodule
